// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn
//   Registered 1-to-N stream demultiplexer. Each input word carries a channel
//   select and is written into that channel's one-entry holding register,
//   where it stays until the channel's consumer takes it. Words addressed to a
//   non-existent channel are accepted, dropped and counted in err_cnt.
//
//   Optional feature macro: DEMUX_BCAST_EN
//     defined   -> in_bcast=1 loads the word into every channel at once
//                  (waits until every channel can take it)
//     undefined -> in_bcast is ignored; routing is by in_sel only
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input word present
//   in_ready   input word accepted this cycle (independent of in_valid)
//   in_data    input word
//   in_sel     destination channel index
//   in_bcast   broadcast request (DEMUX_BCAST_EN only)
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k word at [k*DATA_W +: DATA_W]
//   err_cnt    saturating count of words dropped for out-of-range select
module stream_demux_1xn #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [7:0]               err_cnt
);

  // One extra bit so the range compare also works when N_CH is a power of two.
  localparam logic [SEL_W:0] LP_N_CH = (SEL_W+1)'(N_CH);

  logic [N_CH-1:0]        r_full;
  logic [N_CH*DATA_W-1:0] r_data;
  logic [7:0]             r_err;

  logic [N_CH-1:0]        w_free;
  logic                   w_free_sel;
  logic                   w_sel_ok;
  logic                   w_bcast;
  logic                   w_xfer;
  logic                   w_drop;
  logic [N_CH-1:0]        w_wr;

`ifdef DEMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  logic w_unused_bcast;
  assign w_unused_bcast = in_bcast;
  assign w_bcast        = 1'b0;
`endif

  // A channel can take a word if it is empty or is being drained this cycle.
  assign w_free   = ~r_full | out_ready;
  assign w_sel_ok = ({1'b0, in_sel} < LP_N_CH);

  // Explicit compare loop keeps an out-of-range select from indexing past w_free.
  always_comb begin
    w_free_sel = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (in_sel == SEL_W'(k)) w_free_sel = w_free[k];
    end
  end

  always_comb begin
    if (w_bcast)       in_ready = &w_free;
    else if (w_sel_ok) in_ready = w_free_sel;
    else               in_ready = 1'b1;
  end

  assign w_xfer = in_valid & in_ready;
  assign w_drop = w_xfer & ~w_bcast & ~w_sel_ok;

  always_comb begin
    w_wr = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_wr[k] = w_xfer & (w_bcast | (w_sel_ok & (in_sel == SEL_W'(k))));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= '0;
      r_data <= '0;
      r_err  <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        // A write wins over a drain, so a simultaneous drain+write leaves no bubble.
        if (w_wr[k]) begin
          r_full[k]                     <= 1'b1;
          r_data[k*DATA_W +: DATA_W]    <= in_data;
        end else if (out_ready[k]) begin
          r_full[k]                     <= 1'b0;
        end
      end
      if (w_drop && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

  assign out_valid = r_full;
  assign out_data  = r_data;
  assign err_cnt   = r_err;

endmodule
